// File: rtl/ipv4_frame_tx.sv
// IPv4 frame transmitter: serialises Ethernet + IPv4 (+ optional UDP) headers and a fixed payload as a byte stream.
// Latency: 11 cycles of header checksum after START_TXN acceptance, then one byte per accepted beat.
// Backpressure: TX_VALID stays high for the whole frame; a byte advances only on TX_VALID && TX_READY.
//
// Ports:
//   aclk, areset                  clock, async active-high reset
//   ACCEL_IP/MAC_ADDRESS          source addresses, captured at acceptance
//   DST_IP/MAC_ADDRESS            destination addresses, captured at acceptance
//   PAYLOAD                       user data (MSB byte sent first), captured at acceptance
//   START_TXN / READY_FOR_SEND    request / idle handshake
//   TX_DATA/VALID/FIRST/LAST      byte stream towards the MAC; TX_READY is the MAC's back-pressure
//
// Build option: define IPV4_FRAME_TX_UDP_EN to insert an 8-byte UDP header between IP header and payload.
module ipv4_frame_tx #(
    parameter int unsigned  PAYLOAD_BYTES = 2,
    parameter logic [7:0]   TTL           = 8'h40,
    parameter logic [7:0]   PROTOCOL      = 8'h11,
    parameter logic [15:0]  SRC_PORT      = 16'd5000,
    parameter logic [15:0]  DST_PORT      = 16'd5000
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [31:0]                ACCEL_IP_ADDRESS,
    input  logic [47:0]                ACCEL_MAC_ADDRESS,
    input  logic [31:0]                DST_IP_ADDRESS,
    input  logic [47:0]                DST_MAC_ADDRESS,
    input  logic [8*PAYLOAD_BYTES-1:0] PAYLOAD,
    input  logic                       START_TXN,
    output logic                       READY_FOR_SEND,
    output logic [7:0]                 TX_DATA,
    output logic                       TX_VALID,
    output logic                       TX_FIRST,
    output logic                       TX_LAST,
    input  logic                       TX_READY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CSUM = 3'd1;
    localparam logic [2:0] S_ETH  = 3'd2;
    localparam logic [2:0] S_IP   = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;

`ifdef IPV4_FRAME_TX_UDP_EN
    localparam logic [2:0]  S_UDP     = 3'd5;
    localparam int unsigned UDP_BYTES = 8;
    localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_BYTES);
`else
    localparam int unsigned UDP_BYTES = 0;
    // Port numbers only matter when the UDP header is built in.
    logic [31:0] unused_ports;
    assign unused_ports = {SRC_PORT, DST_PORT};
`endif

    localparam logic [15:0] TOTAL_LEN = 16'(20 + UDP_BYTES + PAYLOAD_BYTES);
    localparam logic [6:0]  PAY_LAST  = 7'(PAYLOAD_BYTES - 1);

    logic [2:0]                 state;
    logic [6:0]                 cnt;
    logic [19:0]                acc;
    logic [15:0]                csum;
    logic [47:0]                dst_mac_q;
    logic [47:0]                src_mac_q;
    logic [31:0]                src_ip_q;
    logic [31:0]                dst_ip_q;
    logic [8*PAYLOAD_BYTES-1:0] pay_q;

    logic [159:0] csum_words;
    logic [111:0] eth_vec;
    logic [159:0] ip_vec;
    logic [15:0]  csum_word;
    logic [16:0]  fold1;
    logic [15:0]  fold2;
    logic         fire;

    // Header words with the checksum field zeroed, in transmit order.
    assign csum_words = {16'h4500, TOTAL_LEN, 16'h0000, 16'h0000, TTL, PROTOCOL,
                         16'h0000, src_ip_q, dst_ip_q};
    assign eth_vec    = {dst_mac_q, src_mac_q, 16'h0800};
    assign ip_vec     = {16'h4500, TOTAL_LEN, 16'h0000, 16'h0000, TTL, PROTOCOL,
                         csum, src_ip_q, dst_ip_q};

    // Word cnt counted from the most significant end; cnt==10 shifts everything out, harmlessly.
    assign csum_word  = 16'(csum_words >> {7'd9 - cnt, 4'b0000});

    // Two carry folds are enough: ten 16-bit words cannot overflow 20 bits,
    // and after the first fold at most one carry remains.
    assign fold1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

    assign fire           = TX_VALID && TX_READY;
    assign READY_FOR_SEND = (state == S_IDLE);

    always_comb begin
        TX_DATA  = 8'h00;
        TX_VALID = 1'b0;
        TX_FIRST = 1'b0;
        TX_LAST  = 1'b0;
        case (state)
            S_ETH: begin
                TX_VALID = 1'b1;
                TX_FIRST = (cnt == 7'd0);
                TX_DATA  = 8'(eth_vec >> {7'd13 - cnt, 3'b000});
            end
            S_IP: begin
                TX_VALID = 1'b1;
                TX_DATA  = 8'(ip_vec >> {7'd19 - cnt, 3'b000});
            end
`ifdef IPV4_FRAME_TX_UDP_EN
            S_UDP: begin
                TX_VALID = 1'b1;
                TX_DATA  = 8'({SRC_PORT, DST_PORT, UDP_LEN, 16'h0000} >> {7'd7 - cnt, 3'b000});
            end
`endif
            S_PAY: begin
                TX_VALID = 1'b1;
                TX_LAST  = (cnt == PAY_LAST);
                TX_DATA  = 8'(pay_q >> {PAY_LAST - cnt, 3'b000});
            end
            default: begin
                TX_DATA  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            cnt       <= 7'd0;
            acc       <= 20'd0;
            csum      <= 16'd0;
            dst_mac_q <= 48'd0;
            src_mac_q <= 48'd0;
            src_ip_q  <= 32'd0;
            dst_ip_q  <= 32'd0;
            pay_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START_TXN) begin
                        dst_mac_q <= DST_MAC_ADDRESS;
                        src_mac_q <= ACCEL_MAC_ADDRESS;
                        src_ip_q  <= ACCEL_IP_ADDRESS;
                        dst_ip_q  <= DST_IP_ADDRESS;
                        pay_q     <= PAYLOAD;
                        acc       <= 20'd0;
                        cnt       <= 7'd0;
                        state     <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (cnt == 7'd10) begin
                        csum  <= ~fold2;
                        acc   <= 20'd0;
                        cnt   <= 7'd0;
                        state <= S_ETH;
                    end else begin
                        acc <= acc + {4'b0, csum_word};
                        cnt <= cnt + 7'd1;
                    end
                end
                S_ETH: begin
                    if (fire) begin
                        if (cnt == 7'd13) begin
                            cnt   <= 7'd0;
                            state <= S_IP;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                S_IP: begin
                    if (fire) begin
                        if (cnt == 7'd19) begin
                            cnt   <= 7'd0;
`ifdef IPV4_FRAME_TX_UDP_EN
                            state <= S_UDP;
`else
                            state <= S_PAY;
`endif
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
`ifdef IPV4_FRAME_TX_UDP_EN
                S_UDP: begin
                    if (fire) begin
                        if (cnt == 7'd7) begin
                            cnt   <= 7'd0;
                            state <= S_PAY;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
`endif
                S_PAY: begin
                    if (fire) begin
                        if (cnt == PAY_LAST) begin
                            cnt   <= 7'd0;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                default: begin
                    cnt   <= 7'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_frame_tx.sv
`timescale 1ns/1ps
module tb_ipv4_frame_tx;

`ifdef IPV4_FRAME_TX_UDP_EN
    localparam int PB  = 4;
    localparam int HDR = 42;
`else
    localparam int PB  = 2;
    localparam int HDR = 34;
`endif
    localparam int FRAME_LEN = HDR + PB;
    localparam logic [7:0]  TTL_V   = 8'h40;
    localparam logic [7:0]  PROTO_V = 8'h11;
    localparam logic [15:0] SPORT   = 16'd5000;
    localparam logic [15:0] DPORT   = 16'd5000;

    typedef logic [8*PB-1:0] pay_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] accel_ip, dst_ip;
    logic [47:0] accel_mac, dst_mac;
    pay_t        payload;
    logic        start_txn, ready_for_send;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_first, tx_last, tx_ready;

    always #5 aclk = ~aclk;

    ipv4_frame_tx #(
        .PAYLOAD_BYTES(PB), .TTL(TTL_V), .PROTOCOL(PROTO_V),
        .SRC_PORT(SPORT), .DST_PORT(DPORT)
    ) dut (
        .aclk(aclk), .areset(areset),
        .ACCEL_IP_ADDRESS(accel_ip), .ACCEL_MAC_ADDRESS(accel_mac),
        .DST_IP_ADDRESS(dst_ip), .DST_MAC_ADDRESS(dst_mac),
        .PAYLOAD(payload), .START_TXN(start_txn), .READY_FOR_SEND(ready_for_send),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_FIRST(tx_first), .TX_LAST(tx_last),
        .TX_READY(tx_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    logic [7:0] expq[$];
    int first_cycle, first_errs, last_errs, hold_errs, valid_drops, rfs_errs;
    int last_seen, timed_out, stall_cycles;
    logic [7:0] stall_data;

    // Reference frame built straight from the protocol field layout.
    function automatic void build_expected(input logic [47:0] dmac, input logic [47:0] smac,
                                           input logic [31:0] sip, input logic [31:0] dip,
                                           input pay_t pay);
        int unsigned total, sum;
        logic [15:0] cs;
        expq.delete();
        total = 20 + PB;
`ifdef IPV4_FRAME_TX_UDP_EN
        total = total + 8;
`endif
        for (int i = 0; i < 6; i++) expq.push_back(8'(dmac >> (8 * (5 - i))));
        for (int i = 0; i < 6; i++) expq.push_back(8'(smac >> (8 * (5 - i))));
        expq.push_back(8'h08); expq.push_back(8'h00);
        sum = 32'h4500 + total + {16'h0, TTL_V, PROTO_V}
            + {16'h0, sip[31:16]} + {16'h0, sip[15:0]} + {16'h0, dip[31:16]} + {16'h0, dip[15:0]};
        while (sum > 32'h0000FFFF) sum = (sum & 32'h0000FFFF) + (sum >> 16);
        cs = ~sum[15:0];
        expq.push_back(8'h45); expq.push_back(8'h00);
        expq.push_back(8'(total >> 8)); expq.push_back(8'(total));
        for (int i = 0; i < 4; i++) expq.push_back(8'h00);
        expq.push_back(TTL_V); expq.push_back(PROTO_V);
        expq.push_back(cs[15:8]); expq.push_back(cs[7:0]);
        for (int i = 0; i < 4; i++) expq.push_back(8'(sip >> (8 * (3 - i))));
        for (int i = 0; i < 4; i++) expq.push_back(8'(dip >> (8 * (3 - i))));
`ifdef IPV4_FRAME_TX_UDP_EN
        expq.push_back(SPORT[15:8]); expq.push_back(SPORT[7:0]);
        expq.push_back(DPORT[15:8]); expq.push_back(DPORT[7:0]);
        expq.push_back(8'((8 + PB) >> 8)); expq.push_back(8'(8 + PB));
        expq.push_back(8'h00); expq.push_back(8'h00);
`endif
        for (int i = 0; i < PB; i++) expq.push_back(8'(pay >> (8 * (PB - 1 - i))));
    endfunction

    // Index of first differing byte, -2 on length difference, -1 when identical.
    function automatic int frame_diff();
        if (got.size() != expq.size()) return -2;
        foreach (expq[i]) if (got[i] !== expq[i]) return i;
        return -1;
    endfunction

    task automatic start_frame();
        @(negedge aclk);
        start_txn = 1'b1;
        @(negedge aclk);
        start_txn = 1'b0;
    endtask

    // Acts as the MAC: drives TX_READY per mode (0 always, 1 random, 2 stall 3 cycles at byte 5)
    // and records accepted bytes plus protocol observations. Entered at the negedge one cycle after acceptance.
    task automatic collect(input int mode, input int abort_at, input int max_cycles);
        int n = 1;
        int stall_left = 3;
        bit seen = 0;
        bit prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        logic prev_first = 1'b0, prev_last = 1'b0;
        logic rdy;
        got.delete();
        first_cycle = -1; first_errs = 0; last_errs = 0; hold_errs = 0; valid_drops = 0;
        rfs_errs = 0; last_seen = 0; timed_out = 0; stall_cycles = 0; stall_data = 8'h00;
        forever begin
            if (abort_at >= 0 && tx_valid && got.size() == abort_at) break;
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && got.size() == 5 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            tx_ready = rdy;
            if (ready_for_send) rfs_errs++;
            if (tx_valid) begin
                if (!seen) first_cycle = n;
                seen = 1;
                if (prev_stall && (tx_data !== prev_data || tx_first !== prev_first || tx_last !== prev_last))
                    hold_errs++;
                if (tx_first !== (got.size() == 0)) first_errs++;
                if (tx_last !== (got.size() == FRAME_LEN - 1)) last_errs++;
                if (tx_last) last_seen++;
                if (!rdy) begin
                    stall_cycles++;
                    stall_data = tx_data;
                end
                prev_stall = !rdy; prev_data = tx_data; prev_first = tx_first; prev_last = tx_last;
                if (rdy) begin
                    got.push_back(tx_data);
                    if (tx_last || got.size() >= FRAME_LEN + 4) break;
                end
            end else if (seen) begin
                valid_drops++;
            end
            if (n >= max_cycles) begin
                timed_out = 1;
                break;
            end
            @(negedge aclk);
            n++;
        end
    endtask

    task automatic set_basic_inputs();
        accel_ip  = 32'hC0A80001;
        dst_ip    = 32'hC0A80002;
        accel_mac = 48'h02_11_22_33_44_55;
        dst_mac   = 48'hAA_BB_CC_DD_EE_FF;
`ifdef IPV4_FRAME_TX_UDP_EN
        payload   = pay_t'(32'hABCD1234);
`else
        payload   = pay_t'(16'hABCD);
`endif
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if ({tx_valid, tx_first, tx_last} !== 3'b000 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: valid/first/last=%b%b%b data=%h, required 000 and 00",
                     tx_valid, tx_first, tx_last, tx_data);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (ready_for_send !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: READY_FOR_SEND=%b, required 1", ready_for_send);
        end
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL idle_outputs: valid=%b data=%h, required 0 and 00", tx_valid, tx_data);
        end
    endtask

    task automatic test_basic_frame();
        logic [63:0] udp_got;
        int d;
        set_basic_inputs();
        build_expected(dst_mac, accel_mac, accel_ip, dst_ip, payload);
        start_frame();
        collect(0, -1, 300);
        checks++;
        if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: frame did not complete, got %0d bytes", got.size()); end
        checks++;
        if (got.size() != FRAME_LEN) begin errors++; $display("FAIL basic_length: %0d bytes, required %0d", got.size(), FRAME_LEN); end
        d = frame_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL basic_content: first difference at %0d", d); end
        while (got.size() < FRAME_LEN) got.push_back(8'h00);
        checks++;
        if (first_cycle != 12) begin errors++; $display("FAIL basic_latency: first valid in cycle %0d, required 12", first_cycle); end
        checks++;
        if (first_errs != 0 || last_errs != 0) begin
            errors++; $display("FAIL basic_flags: first errs %0d last errs %0d, required 0", first_errs, last_errs);
        end
        checks++;
        if (valid_drops != 0) begin errors++; $display("FAIL basic_valid_gap: %0d gaps, required 0", valid_drops); end
`ifdef IPV4_FRAME_TX_UDP_EN
        checks++;
        if ({got[16], got[17]} !== 16'h0020) begin errors++; $display("FAIL basic_total_len: %h%h, required 0020", got[16], got[17]); end
        udp_got = {got[34], got[35], got[36], got[37], got[38], got[39], got[40], got[41]};
        checks++;
        if (udp_got !== 64'h13881388000C0000) begin errors++; $display("FAIL basic_udp_hdr: %h, required 13881388000c0000", udp_got); end
`else
        udp_got = 64'h0;
        checks++;
        if ({got[16], got[17]} !== 16'h0016) begin errors++; $display("FAIL basic_total_len: %h%h, required 0016", got[16], got[17]); end
        checks++;
        if ({got[24], got[25]} !== 16'hF983) begin errors++; $display("FAIL basic_checksum: %h%h, required f983", got[24], got[25]); end
        checks++;
        if ({got[34], got[35]} !== 16'hABCD) begin errors++; $display("FAIL basic_payload: %h%h, required abcd", got[34], got[35]); end
`endif
        @(negedge aclk);
        checks++;
        if (ready_for_send !== 1'b1 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL basic_return_idle: ready=%b valid=%b, required 1 0", ready_for_send, tx_valid);
        end
    endtask

    task automatic test_backpressure();
        int d;
        set_basic_inputs();
        build_expected(dst_mac, accel_mac, accel_ip, dst_ip, payload);
        start_frame();
        collect(2, -1, 300);
        d = frame_diff();
        checks++;
        if (timed_out != 0 || d != -1) begin errors++; $display("FAIL bp_content: timeout=%0d first difference %0d", timed_out, d); end
        checks++;
        if (stall_cycles != 3 || stall_data !== expq[5]) begin
            errors++; $display("FAIL bp_hold: stalled %0d cycles on %h, required 3 on %h", stall_cycles, stall_data, expq[5]);
        end
        checks++;
        if (hold_errs != 0 || valid_drops != 0) begin
            errors++; $display("FAIL bp_stable: hold errs %0d valid gaps %0d, required 0", hold_errs, valid_drops);
        end
        @(negedge aclk);
    endtask

    task automatic test_input_stability();
        int d;
        set_basic_inputs();
        build_expected(dst_mac, accel_mac, accel_ip, dst_ip, payload);
        start_frame();
        dst_ip  = 32'h0A000063;
        payload = ~payload;
        collect(0, -1, 300);
        d = frame_diff();
        checks++;
        if (timed_out != 0 || d != -1) begin errors++; $display("FAIL stable_content: timeout=%0d first difference %0d", timed_out, d); end
`ifndef IPV4_FRAME_TX_UDP_EN
        while (got.size() < FRAME_LEN) got.push_back(8'h00);
        checks++;
        if ({got[24], got[25]} !== 16'hF983) begin errors++; $display("FAIL stable_checksum: %h%h, required f983", got[24], got[25]); end
`endif
        @(negedge aclk);
    endtask

    task automatic test_busy_request();
        int d, extra_valid, rfs_low;
        set_basic_inputs();
        build_expected(dst_mac, accel_mac, accel_ip, dst_ip, payload);
        start_frame();
        rfs_low = 0;
        fork
            collect(0, -1, 300);
            begin
                repeat (30) @(negedge aclk);
                if (ready_for_send === 1'b0) rfs_low = 1;
                start_txn = 1'b1;
                @(negedge aclk);
                start_txn = 1'b0;
            end
        join
        d = frame_diff();
        checks++;
        if (timed_out != 0 || d != -1) begin errors++; $display("FAIL busy_content: timeout=%0d first difference %0d", timed_out, d); end
        checks++;
        if (rfs_errs != 0 || rfs_low != 1) begin
            errors++; $display("FAIL busy_ready: ready high %0d cycles in frame, low at pulse=%0d, required 0 and 1", rfs_errs, rfs_low);
        end
        extra_valid = 0;
        @(negedge aclk);
        checks++;
        if (ready_for_send !== 1'b1) begin errors++; $display("FAIL busy_ready_after: READY_FOR_SEND=%b, required 1", ready_for_send); end
        repeat (40) begin
            if (tx_valid !== 1'b0) extra_valid++;
            @(negedge aclk);
        end
        checks++;
        if (extra_valid != 0) begin errors++; $display("FAIL busy_queued: %0d valid cycles after frame, required 0", extra_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        set_basic_inputs();
        build_expected(dst_mac, accel_mac, accel_ip, dst_ip, payload);
        start_frame();
        collect(0, 20, 300);
        checks++;
        if (got.size() != 20 || timed_out != 0) begin errors++; $display("FAIL midrst_reach: %0d bytes, required 20", got.size()); end
        areset = 1'b1;
        #1;
        checks++;
        if ({tx_valid, tx_first, tx_last} !== 3'b000 || tx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_outputs: valid/first/last=%b%b%b data=%h, required 000 and 00",
                              tx_valid, tx_first, tx_last, tx_data);
        end
        checks++;
        if (last_seen != 0) begin errors++; $display("FAIL midrst_last: TX_LAST seen %0d times, required 0", last_seen); end
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (ready_for_send !== 1'b1) begin errors++; $display("FAIL midrst_ready: READY_FOR_SEND=%b, required 1", ready_for_send); end
        start_frame();
        collect(0, -1, 300);
        d = frame_diff();
        checks++;
        if (timed_out != 0 || d != -1 || first_cycle != 12) begin
            errors++; $display("FAIL midrst_refresh: timeout=%0d diff=%0d first valid cycle %0d, required 0 -1 12", timed_out, d, first_cycle);
        end
        @(negedge aclk);
    endtask

    task automatic test_random_frames();
        int d;
        for (int f = 0; f < 8; f++) begin
            accel_ip  = $urandom;
            dst_ip    = $urandom;
            accel_mac = {16'($urandom), 32'($urandom)};
            dst_mac   = {16'($urandom), 32'($urandom)};
            payload   = pay_t'({$urandom, $urandom});
            build_expected(dst_mac, accel_mac, accel_ip, dst_ip, payload);
            start_frame();
            collect(1, -1, 2000);
            d = frame_diff();
            checks++;
            if (timed_out != 0 || d != -1) begin errors++; $display("FAIL rand_content[%0d]: timeout=%0d first difference %0d", f, timed_out, d); end
            checks++;
            if (hold_errs != 0 || first_errs != 0 || last_errs != 0 || valid_drops != 0) begin
                errors++; $display("FAIL rand_protocol[%0d]: hold %0d first %0d last %0d gaps %0d, required 0",
                                   f, hold_errs, first_errs, last_errs, valid_drops);
            end
            tx_ready = 1'b1;
            @(negedge aclk);
            checks++;
            if (ready_for_send !== 1'b1) begin errors++; $display("FAIL rand_idle[%0d]: READY_FOR_SEND=%b, required 1", f, ready_for_send); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset    = 1'b1;
        start_txn = 1'b0;
        tx_ready  = 1'b1;
        accel_ip  = 32'h0;
        dst_ip    = 32'h0;
        accel_mac = 48'h0;
        dst_mac   = 48'h0;
        payload   = '0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_input_stability();
        test_busy_request();
        test_reset_mid_frame();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
